// File: rtl/arb_muxn_pkg.sv
// Shared constants for the arb_muxn channel multiplexer/arbiter.
package arb_muxn_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for a given channel count.
    function automatic int unsigned sel_width(input int unsigned num_ch);
        return $clog2(num_ch);
    endfunction

endpackage

// File: rtl/arb_muxn_if.sv
// Handshake/bus bundle for arb_muxn.
//   mode/sel       : selection control (direct index or round-robin)
//   in_data/valid  : NUM_CH packed input channels, in_ready back per channel
//   out_*          : one-entry registered output with valid/ready handshake
interface arb_muxn_if
    import arb_muxn_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 8
);
    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    // Master drives the channels and control; slave is the mux itself.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/arb_muxn_rr_pick.sv
// Rotating-priority picker: first asserted request after i_ptr, wrapping.
//   i_req       : request vector
//   i_ptr       : last granted index (search starts at i_ptr+1)
//   o_grant     : granted index (0 when none)
//   o_grant_vld : any request present
module rr_pick
    import arb_muxn_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    localparam int unsigned SEL_W = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_grant_vld
);

    logic [SEL_W-1:0] w_idx;

    // Scan farthest-first so the nearest candidate (ptr+1) is written last and wins.
    always_comb begin
        o_grant     = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        for (int i = int'(NUM_CH); i >= 1; i--) begin
            w_idx = SEL_W'((32'(i_ptr) + 32'(i)) % NUM_CH);
            if (i_req[w_idx]) begin
                o_grant     = w_idx;
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_muxn.sv
// N-channel mux with direct-select or round-robin arbitration into a
// one-entry registered output stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : arb_muxn_if.slave (control, channel inputs, output handshake)
module arb_muxn
    import arb_muxn_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    arb_muxn_if.slave   bus
);

    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load_en;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_idx;
    logic              w_idx_vld;
    logic [NUM_CH-1:0] w_ready;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_word;

    assign w_load_en = !r_out_valid || bus.out_ready;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .i_req       (bus.in_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_vld (w_grant_vld)
    );

    // Selected channel; out-of-range direct index selects nothing.
    always_comb begin
        w_idx     = '0;
        w_idx_vld = 1'b0;
        w_ready   = '0;
        if (bus.mode == MODE_RR) begin
            w_idx     = w_grant;
            w_idx_vld = w_grant_vld;
        end else if (32'(bus.sel) < NUM_CH) begin
            w_idx     = bus.sel;
            w_idx_vld = 1'b1;
        end
        // Ready gated by rst_n so nothing is accepted while reset is held.
        if (w_idx_vld && w_load_en && rst_n) begin
            w_ready[w_idx] = 1'b1;
        end
    end

    assign w_xfer       = |(w_ready & bus.in_valid);
    assign w_word       = bus.in_data[32'(w_idx) * WIDTH +: WIDTH];
    assign bus.in_ready = w_ready;

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SEL_W'(NUM_CH - 1);
        end else if (w_xfer) begin
            r_out_data  <= w_word;
            r_out_ch    <= w_idx;
            r_out_valid <= 1'b1;
            if (bus.mode == MODE_RR) begin
                r_ptr <= w_idx;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_muxn.sv
// Directed self-checking bench for arb_muxn (8-channel and 5-channel builds).
module tb_arb_muxn;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_checks;

    arb_muxn_if #(.WIDTH(16), .NUM_CH(8)) bus8 ();
    arb_muxn_if #(.WIDTH(16), .NUM_CH(5)) bus5 ();

    arb_muxn #(.WIDTH(16), .NUM_CH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    arb_muxn #(.WIDTH(16), .NUM_CH(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        rst_n    = 1'b0;

        bus8.mode      = 1'b0;
        bus8.sel       = 3'd3;
        bus8.in_valid  = 8'h00;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) bus8.in_data[k*16 +: 16] = 16'h1000 + 16'(k);
        bus8.in_data[3*16 +: 16] = 16'hBEEF;

        bus5.mode      = 1'b0;
        bus5.sel       = 3'd6;
        bus5.in_valid  = 5'h1F;
        bus5.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) bus5.in_data[k*16 +: 16] = 16'h5000 + 16'(k);

        // Reset state
        #1;
        check("rst_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_data",  32'(bus8.out_data),  32'd0);
        check("rst_ch",    32'(bus8.out_ch),    32'd0);
        bus8.in_valid = 8'h08;
        #1;
        check("rst_ready", 32'(bus8.in_ready),  32'd0);
        tick();
        check("rst_hold_valid", 32'(bus8.out_valid), 32'd0);
        rst_n = 1'b1;

        // Direct select ch3, first edge after release
        #1;
        check("dir_ready", 32'(bus8.in_ready), 32'h08);
        tick();
        check("dir_valid", 32'(bus8.out_valid), 32'd1);
        check("dir_data",  32'(bus8.out_data),  32'hBEEF);
        check("dir_ch",    32'(bus8.out_ch),    32'd3);

        // Drain with no new input: valid drops, word held
        bus8.in_valid = 8'h00;
        tick();
        check("drain_valid", 32'(bus8.out_valid), 32'd0);
        check("drain_data",  32'(bus8.out_data),  32'hBEEF);
        check("drain_ch",    32'(bus8.out_ch),    32'd3);

        // Round-robin, all requesting; pointer untouched by the direct transfer
        for (int k = 0; k < 8; k++) bus8.in_data[k*16 +: 16] = 16'hA000 + 16'(k);
        bus8.mode     = 1'b1;
        bus8.in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rr_ch%0d", i),   32'(bus8.out_ch),   32'(i % 8));
            check($sformatf("rr_data%0d", i), 32'(bus8.out_data), 32'h0000A000 + 32'(i % 8));
            check($sformatf("rr_vld%0d", i),  32'(bus8.out_valid), 32'd1);
        end

        // Backpressure: held word stable, no ready
        bus8.out_ready = 1'b0;
        #1;
        check("bp_ready", 32'(bus8.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_ch%0d", i),   32'(bus8.out_ch),    32'd0);
            check($sformatf("bp_data%0d", i), 32'(bus8.out_data),  32'hA000);
            check($sformatf("bp_vld%0d", i),  32'(bus8.out_valid), 32'd1);
        end
        // Release: next word on same edge, no bubble
        bus8.out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(bus8.in_ready), 32'h02);
        tick();
        check("bp_rel_ch",  32'(bus8.out_ch),    32'd1);
        check("bp_rel_vld", 32'(bus8.out_valid), 32'd1);

        // Move pointer to 2, then sparse requests ch2/ch5
        tick();
        check("ptr2_ch", 32'(bus8.out_ch), 32'd2);
        bus8.in_valid = 8'h24;
        #1;
        check("sp_ready", 32'(bus8.in_ready), 32'h20);
        tick();
        check("sp_ch_a", 32'(bus8.out_ch), 32'd5);
        tick();
        check("sp_ch_b", 32'(bus8.out_ch), 32'd2);
        tick();
        check("sp_ch_c", 32'(bus8.out_ch), 32'd5);
        check("sp_data", 32'(bus8.out_data), 32'hA005);

        // Changing mode/sel does not disturb a held word
        bus8.out_ready = 1'b0;
        bus8.mode      = 1'b0;
        bus8.sel       = 3'd1;
        tick();
        check("msw_ch",   32'(bus8.out_ch),   32'd5);
        check("msw_data", 32'(bus8.out_data), 32'hA005);
        bus8.mode = 1'b1;
        tick();
        check("msw_ch2",  32'(bus8.out_ch),   32'd5);
        check("msw_ready", 32'(bus8.in_ready), 32'd0);

        // Async reset mid-cycle while holding a word
        bus8.in_valid = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus8.out_valid), 32'd0);
        check("ar_data",  32'(bus8.out_data),  32'd0);
        check("ar_ch",    32'(bus8.out_ch),    32'd0);
        check("ar_ready", 32'(bus8.in_ready),  32'd0);
        tick();
        rst_n          = 1'b1;
        bus8.in_valid  = 8'h0C;
        bus8.out_ready = 1'b1;
        #1;
        check("ar_rel_ready", 32'(bus8.in_ready), 32'h04);
        tick();
        check("ar_rel_ch",  32'(bus8.out_ch),    32'd2);
        check("ar_rel_vld", 32'(bus8.out_valid), 32'd1);

        // 5-channel build: out-of-range select never loads
        check("n5_oor_ready", 32'(bus5.in_ready),  32'd0);
        check("n5_oor_valid", 32'(bus5.out_valid), 32'd0);
        tick();
        check("n5_oor_valid2", 32'(bus5.out_valid), 32'd0);
        bus5.sel = 3'd4;
        #1;
        check("n5_top_ready", 32'(bus5.in_ready), 32'h10);
        tick();
        check("n5_top_ch",   32'(bus5.out_ch),   32'd4);
        check("n5_top_data", 32'(bus5.out_data), 32'h5004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arb_muxn.md
ARB_MUXN -- requirements
Module: arb_muxn

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter NUM_CH, default 8, input channel count (2..16, power of two not required).
REQ-003 Derived constant SEL_W = ceil(log2(NUM_CH)), not overridable.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used in direct mode.
REQ-008 in_data  input  NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  NUM_CH  per-channel data-valid.
REQ-010 in_ready  output  NUM_CH  per-channel accept, combinational.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_ch  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a word.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready); one-entry output register, latency 1 cycle from input transfer to out_valid.
REQ-016 Input transfer on channel k SHALL occur iff in_valid[k] && in_ready[k] at a rising edge; at most one in_ready bit high per cycle.
REQ-017 Direct mode: in_ready[sel] = load_en, all other bits 0; in_ready does not depend on in_valid.
REQ-018 Direct mode, sel >= NUM_CH: in_ready all 0, no load, out register unchanged except drain.
REQ-019 RR mode: grant = first k with in_valid[k] high, searching ptr+1, ptr+2, ... wrapping modulo NUM_CH; in_ready[grant] = load_en; all 0 if no in_valid.
REQ-020 ptr SHALL update to the granted index only on an RR-mode transfer; unchanged otherwise (including direct-mode transfers).
REQ-021 On transfer: out_data <= selected word, out_ch <= index, out_valid <= 1.
REQ-022 No transfer and out_valid && out_ready: out_valid <= 0; out_data, out_ch hold last values.
REQ-023 out_valid && !out_ready: out_data, out_ch, out_valid SHALL remain stable.
REQ-024 Simultaneous drain and transfer (out_valid && out_ready && transfer): new word loaded, out_valid stays 1, no bubble.
REQ-025 mode and sel evaluated combinationally each cycle; changing either SHALL NOT alter a held output word.
REQ-026 With all in_valid held high in RR mode and out_ready=1, grants SHALL rotate 0,1,...,NUM_CH-1,0 with one word per cycle.

Reset
REQ-027 rst_n low SHALL immediately force out_valid=0, out_data=0, out_ch=0, ptr=NUM_CH-1 (channel 0 first priority after reset).
REQ-028 in_ready SHALL be 0 on all bits while rst_n is low; reset mid-transfer discards the held word.
REQ-029 First transfer possible on the first rising edge with rst_n high.

Structure
REQ-030 Shared package SHALL hold MODE_DIRECT=1'b0, MODE_RR=1'b1 constants.
REQ-031 Rotating priority pick SHALL be a sub-module rr_pick (inputs req vector, ptr; outputs grant index, grant_vld), combinational.
REQ-032 Datapath selection SHALL be an indexed part-select, no per-channel hard-coded case.

Verification
REQ-033 Reset then mode=0, sel=3, in_valid=8'h08, in_data ch3=16'hBEEF, out_ready=1 -> next cycle out_valid=1, out_data=16'hBEEF, out_ch=3.
REQ-034 mode=1, in_valid=8'hFF, out_ready=1 for 9 cycles after reset -> out_ch sequence 0,1,2,3,4,5,6,7,0.
REQ-035 out_valid=1, out_ready=0 for 5 cycles, in_valid all high -> in_ready=0, out_data/out_ch unchanged; out_ready=1 -> next word loaded same edge, no bubble.
REQ-036 mode=1, in_valid=8'h24 (ch2, ch5), ptr=2 -> grant ch5, then ch2, then ch5.
REQ-037 NUM_CH=5, mode=0, sel=6 -> in_ready=0, out_valid stays 0.
REQ-038 rst_n asserted while out_valid=1 mid-cycle -> out_valid, out_data, out_ch go 0 without clock edge; first RR grant after release is lowest valid index from 0.
